// File: rtl/shift_reg_univ_if.sv
// Control and data bundle for the universal shift register.
// The master drives mode and data; the slave (the register) returns state and frame status.
interface shift_reg_univ_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH);

    logic              en;
    logic [2:0]        mode;
    logic              ser_in_l;
    logic              ser_in_r;
    logic [WIDTH-1:0]  par_in;
    logic [WIDTH-1:0]  out;
    logic              ser_out_l;
    logic              ser_out_r;
    logic [CNT_W-1:0]  bit_cnt;
    logic              frame_done;

    modport master (
        output en, mode, ser_in_l, ser_in_r, par_in,
        input  out, ser_out_l, ser_out_r, bit_cnt, frame_done
    );

    modport slave (
        input  en, mode, ser_in_l, ser_in_r, par_in,
        output out, ser_out_l, ser_out_r, bit_cnt, frame_done
    );
endinterface

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register: shift, rotate, load and clear,
// with a frame counter that pulses once every WIDTH serial shifts.
module shift_reg_univ #(
    parameter int WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    shift_reg_univ_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_SHL  = 3'd1,
        MODE_SHR  = 3'd2,
        MODE_ROL  = 3'd3,
        MODE_ROR  = 3'd4,
        MODE_LOAD = 3'd5,
        MODE_CLR  = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] cnt;
    logic             done;
    mode_e            op;
    logic             shifting;
    logic             restart;
    logic             last_bit;

    assign op       = mode_e'(bus.mode);
    assign shifting = bus.en && (op == MODE_SHL || op == MODE_SHR);
    assign restart  = bus.en && (op == MODE_LOAD || op == MODE_CLR);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            q    <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            if (bus.en) begin
                case (op)
                    MODE_SHL:  q <= {q[WIDTH-2:0], bus.ser_in_l};
                    MODE_SHR:  q <= {bus.ser_in_r, q[WIDTH-1:1]};
                    MODE_ROL:  q <= {q[WIDTH-2:0], q[WIDTH-1]};
                    MODE_ROR:  q <= {q[0], q[WIDTH-1:1]};
                    MODE_LOAD: q <= bus.par_in;
                    MODE_CLR:  q <= '0;
                    default:   q <= q;
                endcase
            end

            // Only serial shifts advance the frame; load/clear start a fresh frame silently.
            if (shifting) begin
                cnt  <= last_bit ? '0 : cnt + CNT_W'(1);
                done <= last_bit;
            end else begin
                if (restart) begin
                    cnt <= '0;
                end
                done <= 1'b0;
            end
        end
    end

    assign bus.out        = q;
    assign bus.ser_out_l  = q[WIDTH-1];
    assign bus.ser_out_r  = q[0];
    assign bus.bit_cnt    = cnt;
    assign bus.frame_done = done;
endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal shift register. Successor to the fixed 4-bit serial-in shift register.
- Adds selectable width, bidirectional shift, rotate, parallel load, clear and enable.
- A frame counter pulses when WIDTH serial bits have been captured, so the block can serve as a serial-to-parallel deserialiser or a parallel-to-serial serialiser in the datapath.

Parameters:
- WIDTH, 4, register width in bits (>= 2).
- CNT_W, $clog2(WIDTH), width of the bit counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-low reset; sampled on rising clk.
- en  input  1  operation enable; when low, all state holds.
- mode  input  3  operation select (see Behaviour).
- ser_in_l  input  1  serial bit entering at LSB on shift-left.
- ser_in_r  input  1  serial bit entering at MSB on shift-right.
- par_in  input  WIDTH  parallel load data.
- out  output  WIDTH  register contents (registered).
- ser_out_l  output  1  out[WIDTH-1]; combinational from register.
- ser_out_r  output  1  out[0]; combinational from register.
- bit_cnt  output  CNT_W  serial shifts taken in the current frame (registered).
- frame_done  output  1  one-cycle pulse when a frame completes (registered).

Behaviour:
- Reset: rst==0 at a rising clk gives out=0, bit_cnt=0, frame_done=0 on that edge. Reset has priority over en and mode. A mid-frame reset discards the partial frame and does not pulse frame_done.
- en==0: out and bit_cnt hold; frame_done=0.
- mode encoding, applied only when en==1:
  - 3'd0 HOLD: no change.
  - 3'd1 SHL: out <= {out[WIDTH-2:0], ser_in_l}.
  - 3'd2 SHR: out <= {ser_in_r, out[WIDTH-1:1]}.
  - 3'd3 ROL: out <= {out[WIDTH-2:0], out[WIDTH-1]}.
  - 3'd4 ROR: out <= {out[0], out[WIDTH-1:1]}.
  - 3'd5 LOAD: out <= par_in; bit_cnt <= 0.
  - 3'd6 CLR: out <= 0; bit_cnt <= 0.
  - 3'd7: reserved; behaves as HOLD.
- Latency: every operation takes effect on the rising edge where it is sampled. out is valid the following cycle.
- Frame counter:
  - Only SHL and SHR increment bit_cnt. ROL, ROR, HOLD and reserved modes leave it unchanged.
  - On the shift where bit_cnt==WIDTH-1: bit_cnt wraps to 0, and frame_done is 1 on that same edge. frame_done is high for exactly one cycle, coincident with out showing the completed frame.
  - Mixed SHL/SHR shifts within one frame all count toward the frame.
- LOAD or CLR mid-frame restarts the count with no pulse.
- frame_done is 0 in every cycle with no completing shift, including back-to-back LOADs.
- No X propagation: the reserved mode and en==0 must both yield defined hold behaviour.

Test Plan:
- Reset, then drive rst=0 for 2 cycles with en=1 and mode=SHL -> out=4'h0, bit_cnt=0, frame_done=0 throughout.
- WIDTH=4, mode=SHL, ser_in_l=1,0,1,1 on 4 consecutive cycles -> out=4'hB after the 4th edge; frame_done high for that single cycle only; bit_cnt=0.
- mode=SHR, ser_in_r=1,1,0,0 -> out=4'h3; frame_done pulses once; ser_out_r is 1 after the 4th edge.
- LOAD par_in=4'hA, then ROL -> out=4'h5, then ROR -> out=4'hA; bit_cnt stays 0 and no frame_done.
- SHL two bits, then rst=0 for one cycle, then 4 SHL shifts of 1 -> out=4'h0 and no pulse at reset; out=4'hF with frame_done on the 4th shift. Separately, en=0 during a frame holds out and bit_cnt.
- WIDTH=8, SHR 8 bits of alternating 1,0,... -> out=8'h55; frame_done pulses exactly once after 8 shifts; mode=7 holds the value.
